// File: rtl/stream_video_sat_out.sv
// Video output stage: rounds/shifts signed R/G/B sums, saturates to 8 bits and packs them
// into 24-bit AXI4-Stream video. SOF comes from internal counters; tlast is passed through.
module stream_video_sat_out #(
    parameter int SUM_WIDTH = 18,
    parameter int SHIFT     = 0,
    parameter int IMG_W     = 20,
    parameter int IMG_H     = 20
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3*SUM_WIDTH-1:0] s_axis_sum_tdata,
    input  logic                   s_axis_sum_tvalid,
    output logic                   s_axis_sum_tready,
    input  logic                   s_axis_sum_tlast,
    output logic [23:0]            m_axis_video_tdata,
    output logic                   m_axis_video_tvalid,
    input  logic                   m_axis_video_tready,
    output logic                   m_axis_video_tuser,
    output logic                   m_axis_video_tlast,
    output logic                   line_err
);

    localparam int VW = SUM_WIDTH + 1;
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int LW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    // Half an LSB of the shifted result; collapses to 0 when SHIFT is 0.
    localparam logic signed [VW-1:0] RND  = VW'((1 << SHIFT) >> 1);
    localparam logic signed [VW-1:0] MAXV = VW'(255);

    logic          enable;
    logic          accept;
    logic          col_end;
    logic [CW-1:0] col_cnt;
    logic [LW-1:0] line_cnt;

    logic                 s1_valid;
    logic                 s1_user;
    logic                 s1_last;
    logic signed [VW-1:0] s1_r;
    logic signed [VW-1:0] s1_g;
    logic signed [VW-1:0] s1_b;

    function automatic logic signed [VW-1:0] round_shift(input logic [SUM_WIDTH-1:0] s);
        logic signed [VW-1:0] v;
        v = $signed({s[SUM_WIDTH-1], s});
        return (v + RND) >>> SHIFT;
    endfunction

    function automatic logic [7:0] sat8(input logic signed [VW-1:0] v);
        logic [7:0] r;
        if (v[VW-1])
            r = 8'h00;
        else if (v > MAXV)
            r = 8'hFF;
        else
            r = v[7:0];
        return r;
    endfunction

    // The whole pipeline stalls only while the output holds an unaccepted beat.
    assign enable            = !m_axis_video_tvalid || m_axis_video_tready;
    assign s_axis_sum_tready = enable && !reset;
    assign accept            = s_axis_sum_tvalid && s_axis_sum_tready;
    assign col_end           = (col_cnt == CW'(IMG_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt  <= '0;
            line_cnt <= '0;
            line_err <= 1'b0;
        end else begin
            line_err <= accept && (s_axis_sum_tlast != col_end);
            if (accept) begin
                // A missing tlast at the last column still closes the line.
                if (s_axis_sum_tlast || col_end) begin
                    col_cnt  <= '0;
                    line_cnt <= (line_cnt == LW'(IMG_H - 1)) ? '0 : line_cnt + LW'(1);
                end else begin
                    col_cnt <= col_cnt + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid            <= 1'b0;
            s1_user             <= 1'b0;
            s1_last             <= 1'b0;
            s1_r                <= '0;
            s1_g                <= '0;
            s1_b                <= '0;
            m_axis_video_tvalid <= 1'b0;
            m_axis_video_tdata  <= '0;
            m_axis_video_tuser  <= 1'b0;
            m_axis_video_tlast  <= 1'b0;
        end else if (enable) begin
            s1_valid <= accept;
            s1_user  <= accept && (col_cnt == '0) && (line_cnt == '0);
            s1_last  <= accept && s_axis_sum_tlast;
            s1_r     <= round_shift(s_axis_sum_tdata[3*SUM_WIDTH-1:2*SUM_WIDTH]);
            s1_g     <= round_shift(s_axis_sum_tdata[2*SUM_WIDTH-1:SUM_WIDTH]);
            s1_b     <= round_shift(s_axis_sum_tdata[SUM_WIDTH-1:0]);

            m_axis_video_tvalid <= s1_valid;
            m_axis_video_tdata  <= {sat8(s1_r), sat8(s1_g), sat8(s1_b)};
            m_axis_video_tuser  <= s1_user;
            m_axis_video_tlast  <= s1_last;
        end
    end

endmodule

// File: tb/tb_stream_video_sat_out.sv
// Bench for stream_video_sat_out: directed vectors on two instances (SHIFT=0 with a 4x3 frame,
// SHIFT=4), expected beats queued at accept and popped by monitors at the output.
module tb_stream_video_sat_out;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT A: SHIFT=0, 4x3 frame ----------------
    logic [53:0] s_tdata_a = '0;
    logic        s_tvalid_a = 1'b0;
    logic        s_tready_a;
    logic        s_tlast_a = 1'b0;
    logic [23:0] m_tdata_a;
    logic        m_tvalid_a;
    logic        m_tready_a = 1'b1;
    logic        m_tuser_a;
    logic        m_tlast_a;
    logic        line_err_a;

    stream_video_sat_out #(.SUM_WIDTH(18), .SHIFT(0), .IMG_W(4), .IMG_H(3)) dut_a (
        .clk                 (clk),
        .reset               (reset),
        .s_axis_sum_tdata    (s_tdata_a),
        .s_axis_sum_tvalid   (s_tvalid_a),
        .s_axis_sum_tready   (s_tready_a),
        .s_axis_sum_tlast    (s_tlast_a),
        .m_axis_video_tdata  (m_tdata_a),
        .m_axis_video_tvalid (m_tvalid_a),
        .m_axis_video_tready (m_tready_a),
        .m_axis_video_tuser  (m_tuser_a),
        .m_axis_video_tlast  (m_tlast_a),
        .line_err            (line_err_a)
    );

    // ---------------- DUT B: SHIFT=4 ----------------
    logic [53:0] s_tdata_b = '0;
    logic        s_tvalid_b = 1'b0;
    logic        s_tready_b;
    logic [23:0] m_tdata_b;
    logic        m_tvalid_b;
    logic        m_tuser_b;
    logic        m_tlast_b;
    logic        line_err_b;

    stream_video_sat_out #(.SUM_WIDTH(18), .SHIFT(4)) dut_b (
        .clk                 (clk),
        .reset               (reset),
        .s_axis_sum_tdata    (s_tdata_b),
        .s_axis_sum_tvalid   (s_tvalid_b),
        .s_axis_sum_tready   (s_tready_b),
        .s_axis_sum_tlast    (1'b0),
        .m_axis_video_tdata  (m_tdata_b),
        .m_axis_video_tvalid (m_tvalid_b),
        .m_axis_video_tready (1'b1),
        .m_axis_video_tuser  (m_tuser_b),
        .m_axis_video_tlast  (m_tlast_b),
        .line_err            (line_err_b)
    );

    // ---------------- scoreboard state ----------------
    logic [25:0] exp_a_q[$];   // {tuser, tlast, tdata}
    logic [23:0] exp_b_q[$];
    int          lat_b_q[$];
    int          checks = 0;
    int          failures = 0;
    bit          pend_acc = 1'b0;
    bit          pend_err = 1'b0;
    bit          exp_le = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // line_err is expected one cycle after an accept that was flagged as a mismatch.
    always @(posedge clk) exp_le = reset ? 1'b0 : (pend_acc & pend_err);

    // ---------------- driver tasks (entered at a falling edge) ----------------
    task automatic send_a(input int r, input int g, input int b, input bit last,
                          input logic [23:0] exp_data, input bit exp_user, input bit exp_err);
        int  waited = 0;
        bit  done = 1'b0;
        s_tdata_a  = {r[17:0], g[17:0], b[17:0]};
        s_tlast_a  = last;
        s_tvalid_a = 1'b1;
        while (!done) begin
            #1;
            if (s_tready_a) begin
                pend_acc = 1'b1;
                pend_err = exp_err;
                exp_a_q.push_back({exp_user, last, exp_data});
                done = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            pend_acc = 1'b0;
            if (!done) begin
                waited++;
                if (waited > 50) begin
                    checks++;
                    failures++;
                    $display("FAIL send_a_timeout: s_tready stuck at 0 expected 1");
                    done = 1'b1;
                end
            end
        end
        s_tvalid_a = 1'b0;
        s_tlast_a  = 1'b0;
    endtask

    task automatic send_s(input int k, input bit last, input bit exp_user, input bit exp_err);
        logic [7:0] k8;
        k8 = 8'(k);
        send_a(k, k, k, last, {k8, k8, k8}, exp_user, exp_err);
    endtask

    task automatic send_b(input int r, input int g, input int b, input logic [23:0] exp_data);
        s_tdata_b  = {r[17:0], g[17:0], b[17:0]};
        s_tvalid_b = 1'b1;
        #1;
        checks++;
        if (!s_tready_b) begin
            failures++;
            $display("FAIL send_b_ready: got 0 expected 1");
        end else begin
            exp_b_q.push_back(exp_data);
            lat_b_q.push_back(cyc);
        end
        @(posedge clk);
        @(negedge clk);
        s_tvalid_b = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- monitors ----------------
    initial begin
        logic [25:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset) begin
                check("line_err", line_err_a, exp_le);
                if (m_tvalid_a) begin
                    if (exp_a_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL a_unexpected_beat: got tdata %0h expected no beat", m_tdata_a);
                    end else if (m_tready_a) begin
                        e = exp_a_q.pop_front();
                        check("a_tdata", m_tdata_a, e[23:0]);
                        check("a_tuser", m_tuser_a, e[25]);
                        check("a_tlast", m_tlast_a, e[24]);
                    end else begin
                        e = exp_a_q[0];
                        check("a_hold_tdata", m_tdata_a, e[23:0]);
                        check("a_hold_tuser", m_tuser_a, e[25]);
                        check("a_stall_s_tready", s_tready_a, 0);
                    end
                end
            end
        end
    end

    initial begin
        int acc;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && m_tvalid_b) begin
                if (exp_b_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL b_unexpected_beat: got tdata %0h expected no beat", m_tdata_b);
                end else begin
                    check("b_tdata", m_tdata_b, exp_b_q.pop_front());
                    acc = lat_b_q.pop_front();
                    check("b_latency", cyc, acc + 2);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        repeat (2) @(negedge clk);
        #1;
        check("reset_s_tready", s_tready_a, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_tvalid", m_tvalid_a, 0);
        check("reset_tdata", m_tdata_a, 0);
        check("reset_tuser", m_tuser_a, 0);
        check("reset_tlast", m_tlast_a, 0);
        check("reset_line_err", line_err_a, 0);
        check("reset_tvalid_b", m_tvalid_b, 0);
        @(negedge clk);

        // Rounding and saturation with SHIFT=4.
        send_b(24, -1, 4095, 24'h0200FF);
        send_b(-8, 23, 4088, 24'h0001FF);
        idle(1);
        send_b(2047, 40, -200, 24'h800300);
        send_b(131071, -131072, 7, 24'hFF0000);
        send_b(-9, 8, 7, 24'h000100);
        idle(4);

        // Saturation with SHIFT=0, then reset mid-frame after 6 beats.
        send_a(255, 256, -32768, 1'b0, 24'hFFFF00, 1'b1, 1'b0);
        send_a(128, 0, 7, 1'b0, 24'h800007, 1'b0, 1'b0);
        send_a(300, -5, 100, 1'b0, 24'hFF0064, 1'b0, 1'b0);
        send_a(0, 0, 0, 1'b1, 24'h000000, 1'b0, 1'b0);
        send_a(10, 20, 30, 1'b0, 24'h0A141E, 1'b0, 1'b0);
        send_a(-1, 131071, 0, 1'b0, 24'h00FF00, 1'b0, 1'b0);
        reset = 1'b1;
        exp_a_q.delete();
        #1;
        check("midreset_s_tready", s_tready_a, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midreset_tvalid", m_tvalid_a, 0);
        check("midreset_line_err", line_err_a, 0);
        @(negedge clk);

        // Full 4x3 frame twice over: SOF on beats 0 and 12 only.
        for (int i = 0; i < 24; i++) begin
            send_a(i * 10, 255 - i, i * 3, (i % 4) == 3,
                   {8'(i * 10), 8'(255 - i), 8'(i * 3)}, (i == 0) || (i == 12), 1'b0);
            if (i == 9) idle(2);
        end
        idle(3);

        // Output back-pressure for 5 cycles while the source keeps offering beats.
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send_a(i + 1, 200, 17 * i, (i % 4) == 3,
                           {8'(i + 1), 8'd200, 8'(17 * i)}, i == 0, 1'b0);
            end
            begin
                repeat (3) @(negedge clk);
                m_tready_a = 1'b0;
                repeat (5) @(negedge clk);
                m_tready_a = 1'b1;
            end
        join
        idle(3);

        // Line-length errors: early tlast on line 2, then a missing tlast on line 0.
        send_s(1, 1'b0, 1'b0, 1'b0);
        send_s(2, 1'b0, 1'b0, 1'b0);
        send_s(3, 1'b1, 1'b0, 1'b1);
        send_s(4, 1'b0, 1'b1, 1'b0);
        send_s(5, 1'b0, 1'b0, 1'b0);
        idle(1);
        send_s(6, 1'b0, 1'b0, 1'b0);
        send_s(7, 1'b0, 1'b0, 1'b1);
        send_s(8, 1'b0, 1'b0, 1'b0);
        send_s(9, 1'b0, 1'b0, 1'b0);
        send_s(10, 1'b0, 1'b0, 1'b0);
        send_s(11, 1'b1, 1'b0, 1'b0);
        send_s(12, 1'b0, 1'b0, 1'b0);
        send_s(13, 1'b0, 1'b0, 1'b0);
        send_s(14, 1'b0, 1'b0, 1'b0);
        send_s(15, 1'b1, 1'b0, 1'b0);
        send_s(16, 1'b0, 1'b1, 1'b0);
        idle(6);

        check("a_queue_drained", exp_a_q.size(), 0);
        check("b_queue_drained", exp_b_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
